fir_mac_engine: RTL and testbench



---
 rtl/fir_mac_engine.sv | 169 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// Sequential 11-tap FIR: one MAC per cycle, fed from two single-port BRAMs with registered reads.
// The sample history lives in the data BRAM as a circular buffer indexed by wr_ptr_q.
module fir_mac_engine #(
  parameter int NUM_TAP = 11,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              ap_start,
  input  logic [31:0]       data_length,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  output logic              ss_tready,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic              tap_EN,
  output logic [3:0]        tap_WE,
  output logic [ADDR_W-1:0] tap_A,
  input  logic [DATA_W-1:0] tap_Do,
  output logic              data_EN,
  output logic [3:0]        data_WE,
  output logic [ADDR_W-1:0] data_A,
  output logic [DATA_W-1:0] data_Di,
  input  logic [DATA_W-1:0] data_Do
);

  localparam int CW = $clog2(NUM_TAP + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TAP - 1);
  localparam logic [CW-1:0] MAC_END  = CW'(NUM_TAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     step_q;
  logic [CW-1:0]     wr_ptr_q;
  logic [31:0]       cnt_q;
  logic [31:0]       len_q;
  logic [DATA_W-1:0] acc_q;

  logic [CW-1:0]     rd_idx;
  logic [DATA_W-1:0] prod;
  logic              last_out;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CW-1:0] k);
    return ADDR_W'({k, 2'b00});
  endfunction

  // Newest sample sits at wr_ptr_q; tap c pairs with the sample c steps older.
  assign rd_idx   = (wr_ptr_q >= step_q) ? (wr_ptr_q - step_q)
                                         : (wr_ptr_q + MAC_END - step_q);
  assign prod     = tap_Do * data_Do;
  assign last_out = ((cnt_q + 32'd1) == len_q);

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            len_q    <= data_length;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            step_q   <= '0;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (step_q == LAST_IDX) begin
            step_q  <= '0;
            state_q <= (len_q == 32'd0) ? S_DONE : S_WAIT_IN;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            acc_q   <= '0;
            step_q  <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          // Read data lags the address by one cycle, so accumulation runs on steps 1..NUM_TAP.
          if (step_q != '0) acc_q <= acc_q + prod;
          if (step_q == MAC_END) begin
            step_q  <= '0;
            state_q <= S_OUT;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_OUT: begin
          if (sm_tready) begin
            cnt_q    <= cnt_q + 32'd1;
            wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            state_q  <= last_out ? S_DONE : S_WAIT_IN;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ap_idle   = (state_q == S_IDLE);
    ap_done   = (state_q == S_DONE);
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tdata  = '0;
    sm_tlast  = 1'b0;
    tap_EN    = 1'b0;
    tap_WE    = 4'h0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;
    case (state_q)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(step_q);
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = word_addr(wr_ptr_q);
          data_Di = ss_tdata;
        end
      end
      S_MAC: begin
        if (step_q <= LAST_IDX) begin
          tap_EN  = 1'b1;
          tap_A   = word_addr(step_q);
          data_EN = 1'b1;
          data_A  = word_addr(rd_idx);
        end
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tdata  = acc_q;
        sm_tlast  = last_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with behavioural tap/data BRAMs (registered read).
module tb_fir_mac_engine;

  logic        clk;
  logic        rst_n;
  logic        ap_start;
  logic [31:0] data_length;
  logic        ap_idle;
  logic        ap_done;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic        tap_EN;
  logic [3:0]  tap_WE;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic        data_EN;
  logic [3:0]  data_WE;
  logic [11:0] data_A;
  logic [31:0] data_Di;
  logic [31:0] data_Do;

  logic [31:0] tap_mem  [0:15];
  logic [31:0] data_mem [0:15];
  logic [31:0] xv [0:15];
  logic [31:0] ev [0:15];

  int total = 0;
  int bad   = 0;

  fir_mac_engine dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .ap_start   (ap_start),
    .data_length(data_length),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tready  (ss_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .sm_tready  (sm_tready),
    .tap_EN     (tap_EN),
    .tap_WE     (tap_WE),
    .tap_A      (tap_A),
    .tap_Do     (tap_Do),
    .data_EN    (data_EN),
    .data_WE    (data_WE),
    .data_A     (data_A),
    .data_Di    (data_Di),
    .data_Do    (data_Do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tap_EN) tap_Do <= tap_mem[tap_A[5:2]];
  end

  // Stale history is seeded with junk so a missing clear shows up in the outputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) data_mem[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (data_EN) begin
      if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
      data_Do <= data_mem[data_A[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input int len, input int bp_at);
    int t;
    data_length = 32'(len);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      t = 0;
      while (!ss_tready && t < 60) begin @(negedge clk); t++; end
      chk($sformatf("%s_in_rdy%0d", tag, i), 32'(ss_tready), 32'd1);
      ss_tvalid = 1'b1;
      ss_tdata  = xv[i];
      @(negedge clk);
      ss_tvalid = 1'b0;
      if (i == bp_at) sm_tready = 1'b0;
      t = 0;
      while (!sm_tvalid && t < 60) begin @(negedge clk); t++; end
      chk($sformatf("%s_y%0d", tag, i), sm_tdata, ev[i]);
      chk($sformatf("%s_last%0d", tag, i), 32'(sm_tlast), 32'(i == len - 1));
      $display("%s out %0d: y=%h last=%0b", tag, i, sm_tdata, sm_tlast);
      if (i == bp_at) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("%s_bp_valid%0d", tag, k), 32'(sm_tvalid), 32'd1);
          chk($sformatf("%s_bp_data%0d", tag, k), sm_tdata, ev[i]);
          chk($sformatf("%s_bp_ssrdy%0d", tag, k), 32'(ss_tready), 32'd0);
          chk($sformatf("%s_bp_en%0d", tag, k), 32'({tap_EN, data_EN}), 32'd0);
        end
        sm_tready = 1'b1;
      end
      @(negedge clk);
    end
    t = 0;
    while (!ap_done && t < 60) begin @(negedge clk); t++; end
    chk({tag, "_done"}, 32'(ap_done), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(ap_done), 32'd0);
    chk({tag, "_idle"}, 32'(ap_idle), 32'd1);
  endtask

  initial begin
    int t;
    bit saw_out;
    rst_n = 1'b0;
    ap_start = 1'b0;
    data_length = '0;
    ss_tvalid = 1'b0;
    ss_tdata = '0;
    sm_tready = 1'b1;
    for (int i = 0; i < 16; i++) tap_mem[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_idle", 32'(ap_idle), 32'd1);
    chk("rst_done", 32'(ap_done), 32'd0);
    chk("rst_ssrdy", 32'(ss_tready), 32'd0);
    chk("rst_smvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_en", 32'({tap_EN, data_EN}), 32'd0);
    chk("rst_we", 32'(data_WE), 32'd0);
    chk("rst_addr", 32'({tap_A, data_A}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse with taps 1..11, plus a 5-cycle stall on output 3.
    for (int i = 0; i < 11; i++) tap_mem[i] = 32'(i + 1);
    for (int i = 0; i < 12; i++) begin
      xv[i] = (i == 0) ? 32'd1 : 32'd0;
      ev[i] = (i < 11) ? 32'(i + 1) : 32'd0;
    end
    run_job("impulse", 12, 3);

    // Step with unit taps; 15 samples wrap the history pointer.
    for (int i = 0; i < 11; i++) tap_mem[i] = 32'd1;
    for (int i = 0; i < 15; i++) begin
      xv[i] = 32'd2;
      ev[i] = (i < 11) ? 32'(2 * (i + 1)) : 32'd22;
    end
    run_job("step", 15, -1);

    // Restart must not see the step history.
    for (int i = 0; i < 11; i++) tap_mem[i] = 32'(i + 1);
    xv[0] = 32'd5; xv[1] = 32'd0; xv[2] = 32'd0;
    ev[0] = 32'd5; ev[1] = 32'd10; ev[2] = 32'd15;
    run_job("restart", 3, -1);

    for (int i = 0; i < 11; i++) tap_mem[i] = 32'd0;
    tap_mem[0] = 32'h0001_0000;
    xv[0] = 32'h0001_0000;
    ev[0] = 32'h0000_0000;
    run_job("arith_ovf", 1, -1);
    tap_mem[0] = 32'hFFFF_FFFF;
    xv[0] = 32'd5;
    ev[0] = 32'hFFFF_FFFB;
    run_job("arith_neg", 1, -1);

    // Reset while in MAC.
    data_length = 32'd5;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    t = 0;
    while (!ss_tready && t < 60) begin @(negedge clk); t++; end
    chk("mrst_in_rdy", 32'(ss_tready), 32'd1);
    ss_tvalid = 1'b1;
    ss_tdata = 32'd7;
    @(negedge clk);
    ss_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_in_mac", 32'({tap_EN, data_EN}), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_idle", 32'(ap_idle), 32'd1);
    chk("mrst_smvalid", 32'(sm_tvalid), 32'd0);
    chk("mrst_en", 32'({tap_EN, data_EN}), 32'd0);
    $display("mid-MAC reset: idle=%0b en=%0b%0b", ap_idle, tap_EN, data_EN);
    rst_n = 1'b1;
    @(negedge clk);

    // data_length == 0: eleven clear cycles then a done pulse, no outputs.
    data_length = 32'd0;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    chk("len0_clr_en", 32'(data_EN), 32'd1);
    chk("len0_clr_we", 32'(data_WE), 32'hF);
    chk("len0_clr_a0", 32'(data_A), 32'd0);
    t = 0;
    saw_out = 1'b0;
    while (!ap_done && t < 60) begin
      @(negedge clk);
      t++;
      if (sm_tvalid) saw_out = 1'b1;
    end
    chk("len0_done", 32'(ap_done), 32'd1);
    chk("len0_clear_cycles", 32'(t), 32'd11);
    chk("len0_no_out", 32'(saw_out), 32'd0);
    $display("len0: done after %0d cycles", t);
    @(negedge clk);
    chk("len0_done_pulse", 32'(ap_done), 32'd0);
    chk("len0_idle", 32'(ap_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
